// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared state encodings and constants for the MIPS pipeline control unit.
package mips_ctrl_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STEP   = 3'd2,
        S_DRAIN  = 3'd3,
        S_HALTED = 3'd4
    } state_e;
    localparam int DRAIN_CYCLES_DEF = 4;
    localparam int REG_ZERO         = 0;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use comparator between the load in EX and the operands in ID.
module hazard_detect
    import mips_ctrl_pkg::*;
#(
    parameter int NB_ADDR = 5
) (
    input  logic               i_mem_read_IDEX,
    input  logic [NB_ADDR-1:0] i_rt_IDEX,
    input  logic [NB_ADDR-1:0] i_rs_IFID,
    input  logic [NB_ADDR-1:0] i_rt_IFID,
    output logic               o_stall
);
    // $zero is hardwired, so a load targeting it never creates a dependency
    assign o_stall = i_mem_read_IDEX && (i_rt_IDEX != NB_ADDR'(REG_ZERO)) &&
                     ((i_rt_IDEX == i_rs_IFID) || (i_rt_IDEX == i_rt_IFID));
endmodule

// File: rtl/pipeline_control_unit.sv
// pipeline_control_unit: run/step/halt sequencer and stall/flush/bubble generator for the 5-stage pipeline.
module pipeline_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int NB_ADDR      = 5,
    parameter int NB_DRAIN     = 3,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic               i_run,
    input  logic               i_step,
    input  logic               i_halt_ID,
    input  logic               i_branch_taken,
    input  logic               i_mem_read_IDEX,
    input  logic [NB_ADDR-1:0] i_rt_IDEX,
    input  logic [NB_ADDR-1:0] i_rs_IFID,
    input  logic [NB_ADDR-1:0] i_rt_IFID,
    output logic               o_pc_en,
    output logic               o_ifid_en,
    output logic               o_ifid_flush,
    output logic               o_idex_bubble,
    output logic               o_pipe_en,
    output logic               o_halted,
    output logic [2:0]         o_state
);
    state_e              state_q, state_d;
    logic [NB_DRAIN-1:0] drain_cnt_q, drain_cnt_d;
    logic                stall;

    hazard_detect #(.NB_ADDR(NB_ADDR)) u_hazard (
        .i_mem_read_IDEX(i_mem_read_IDEX),
        .i_rt_IDEX      (i_rt_IDEX),
        .i_rs_IFID      (i_rs_IFID),
        .i_rt_IFID      (i_rt_IFID),
        .o_stall        (stall)
    );

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        o_pc_en       = 1'b0;
        o_ifid_en     = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_pipe_en     = 1'b0;
        o_halted      = 1'b0;
        case (state_q)
            S_IDLE: state_d = i_run ? S_RUN : (i_step ? S_STEP : S_IDLE);
            S_RUN, S_STEP: begin
                o_pipe_en = 1'b1;
                // a stall masks branch and halt; they are seen again once the load clears
                if (stall) begin
                    o_idex_bubble = 1'b1;
                end else if (i_halt_ID) begin
                    state_d     = S_DRAIN;
                    drain_cnt_d = '0;
                end else begin
                    o_pc_en      = 1'b1;
                    o_ifid_en    = 1'b1;
                    o_ifid_flush = i_branch_taken;
                end
                if (state_q == S_STEP && state_d != S_DRAIN) state_d = S_IDLE;
            end
            S_DRAIN: begin
                o_pipe_en     = 1'b1;
                o_idex_bubble = 1'b1;
                drain_cnt_d   = drain_cnt_q + 1'b1;
                if (drain_cnt_q == NB_DRAIN'(DRAIN_CYCLES - 1)) state_d = S_HALTED;
            end
            S_HALTED: o_halted = 1'b1;
            default:  state_d = S_IDLE;
        endcase
    end

    assign o_state = state_q;
endmodule

// File: tb/tb_pipeline_control_unit.sv
// tb_pipeline_control_unit: directed and random stimulus against a behavioural model of the control unit.
module tb_pipeline_control_unit;
    localparam int NA = 5;
    localparam int DC = 4;

    logic          clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_run = 0, i_step = 0, i_halt_ID = 0, i_branch_taken = 0, i_mem_read_IDEX = 0;
    logic [NA-1:0] i_rt_IDEX = '0, i_rs_IFID = '0, i_rt_IFID = '0;
    logic          o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_pipe_en, o_halted;
    logic [2:0]    o_state;

    int n_chk = 0, n_fail = 0;
    int m_mode = 0;
    int m_left = 0;

    always #5 clk = ~clk;

    pipeline_control_unit #(.NB_ADDR(NA), .NB_DRAIN(3), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_run(i_run), .i_step(i_step), .i_halt_ID(i_halt_ID),
        .i_branch_taken(i_branch_taken), .i_mem_read_IDEX(i_mem_read_IDEX), .i_rt_IDEX(i_rt_IDEX),
        .i_rs_IFID(i_rs_IFID), .i_rt_IFID(i_rt_IFID), .o_pc_en(o_pc_en), .o_ifid_en(o_ifid_en),
        .o_ifid_flush(o_ifid_flush), .o_idex_bubble(o_idex_bubble), .o_pipe_en(o_pipe_en),
        .o_halted(o_halted), .o_state(o_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
        end
    endtask

    function automatic bit load_use();
        return i_mem_read_IDEX && i_rt_IDEX != 0 && (i_rt_IDEX == i_rs_IFID || i_rt_IDEX == i_rt_IFID);
    endfunction

    task automatic check_outputs();
        bit act = (m_mode == 1 || m_mode == 2);
        bit adv = act && !load_use() && !i_halt_ID;
        check_eq("pc_en", o_pc_en, adv);
        check_eq("ifid_en", o_ifid_en, adv);
        check_eq("ifid_flush", o_ifid_flush, adv && i_branch_taken);
        check_eq("idex_bubble", o_idex_bubble, (act && load_use()) || m_mode == 3);
        check_eq("pipe_en", o_pipe_en, act || m_mode == 3);
        check_eq("halted", o_halted, m_mode == 4);
        check_eq("state", o_state, m_mode);
    endtask

    task automatic model_step();
        if (!i_rst_n) begin
            m_mode = 0;
            m_left = 0;
        end else if (m_mode == 0) begin
            m_mode = i_run ? 1 : (i_step ? 2 : 0);
        end else if (m_mode == 1 || m_mode == 2) begin
            if (!load_use() && i_halt_ID) begin
                m_mode = 3;
                m_left = DC;
            end else if (m_mode == 2) begin
                m_mode = 0;
            end
        end else if (m_mode == 3) begin
            m_left--;
            if (m_left == 0) m_mode = 4;
        end
    endtask

    task automatic tick();
        #1 check_outputs();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {i_run, i_step, i_halt_ID, i_branch_taken, i_mem_read_IDEX} = '0;
        i_rt_IDEX = '0;
        i_rs_IFID = '0;
        i_rt_IFID = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        #1 check_outputs();
        @(negedge clk);
        i_rst_n = 1'b1;
        repeat (10) tick();
        i_step = 1; tick();
        i_step = 0; tick(); tick();
        i_run = 1; tick();
        i_run = 0;
        i_mem_read_IDEX = 1; i_rt_IDEX = 5; i_rs_IFID = 5; tick();
        i_rt_IDEX = 0; i_rs_IFID = 0; tick();
        clear_inputs();
        i_branch_taken = 1; tick();
        i_mem_read_IDEX = 1; i_rt_IDEX = 5; i_rt_IFID = 5; tick();
        clear_inputs();
        i_halt_ID = 1; i_branch_taken = 1; tick();
        clear_inputs();
        repeat (DC) tick();
        i_run = 1; tick();
        i_run = 0; i_step = 1; tick();
        clear_inputs(); tick();
        i_rst_n = 0; m_mode = 0; m_left = 0; tick();
        i_rst_n = 1; i_run = 1; tick();
        i_run = 0; i_halt_ID = 1; tick();
        i_halt_ID = 0; tick(); tick();
        i_rst_n = 0; m_mode = 0; m_left = 0; tick();
        i_rst_n = 1; i_step = 1; tick();
        i_step = 0; tick(); tick();
        i_run = 1; i_step = 1; tick();
        clear_inputs(); tick(); tick();
        for (int c = 0; c < 3000; c++) begin
            i_run           = ($urandom_range(0, 15) == 0);
            i_step          = ($urandom_range(0, 7) == 0);
            i_halt_ID       = ($urandom_range(0, 39) == 0);
            i_branch_taken  = ($urandom_range(0, 2) == 0);
            i_mem_read_IDEX = 1'($urandom_range(0, 1));
            i_rt_IDEX       = NA'($urandom_range(0, 3));
            i_rs_IFID       = NA'($urandom_range(0, 3));
            i_rt_IFID       = NA'($urandom_range(0, 3));
            if (m_mode >= 3 && $urandom_range(0, 7) == 0) begin
                i_rst_n = 0;
                m_mode  = 0;
                m_left  = 0;
            end else begin
                i_rst_n = 1;
            end
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
